// File: rtl/sap1_pkg.sv
// SAP-1 shared constants: opcodes, T-state indices, control-word bit layout
// and the combinational control decoder used by the sequencer.
package sap1_pkg;

    localparam int SAP1_NUM_T = 6;

    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CW_PC_OUT     = 0;
    localparam int CW_PC_INC     = 1;
    localparam int CW_MAR_LOAD   = 2;
    localparam int CW_RAM_OUT    = 3;
    localparam int CW_INSTR_LOAD = 4;
    localparam int CW_INSTR_SEND = 5;
    localparam int CW_A_LOAD     = 6;
    localparam int CW_A_OUT      = 7;
    localparam int CW_B_LOAD     = 8;
    localparam int CW_ALU_SUB    = 9;
    localparam int CW_ALU_OUT    = 10;
    localparam int CW_OUT_LOAD   = 11;
    localparam int CW_W          = 12;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // One control word per T-state; opcode only matters from T4 onward.
    function automatic ctrl_word_t decode(input logic [SAP1_NUM_T-1:0] t,
                                          input logic [3:0]            op);
        ctrl_word_t cw;
        cw = '0;
        if (t[T1]) begin
            cw[CW_PC_OUT]   = 1'b1;
            cw[CW_MAR_LOAD] = 1'b1;
        end
        if (t[T2]) begin
            cw[CW_PC_INC] = 1'b1;
        end
        if (t[T3]) begin
            cw[CW_RAM_OUT]    = 1'b1;
            cw[CW_INSTR_LOAD] = 1'b1;
        end
        if (t[T4]) begin
            case (op)
                OP_LDA, OP_ADD, OP_SUB: begin
                    cw[CW_INSTR_SEND] = 1'b1;
                    cw[CW_MAR_LOAD]   = 1'b1;
                end
                OP_OUT: begin
                    cw[CW_A_OUT]    = 1'b1;
                    cw[CW_OUT_LOAD] = 1'b1;
                end
                default: ;
            endcase
        end
        if (t[T5]) begin
            case (op)
                OP_LDA: begin
                    cw[CW_RAM_OUT] = 1'b1;
                    cw[CW_A_LOAD]  = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    cw[CW_RAM_OUT] = 1'b1;
                    cw[CW_B_LOAD]  = 1'b1;
                    cw[CW_ALU_SUB] = (op == OP_SUB);
                end
                default: ;
            endcase
        end
        if (t[T6]) begin
            case (op)
                OP_ADD, OP_SUB: begin
                    cw[CW_ALU_OUT] = 1'b1;
                    cw[CW_A_LOAD]  = 1'b1;
                    cw[CW_ALU_SUB] = (op == OP_SUB);
                end
                default: ;
            endcase
        end
        return cw;
    endfunction

endpackage

// File: rtl/t_ring_counter.sv
// One-hot T-state ring: rotates on advance, jumps back to T1 on restart,
// and freezes while hold is asserted.
module t_ring_counter #(
    parameter int NUM_T = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance_i,
    input  logic             restart_i,
    input  logic             hold_i,
    output logic [NUM_T-1:0] t_state_o
);

    logic [NUM_T-1:0] t_q;
    logic [NUM_T-1:0] t_d;
    logic [NUM_T-1:0] rotated;

    for (genvar gi = 0; gi < NUM_T; gi++) begin : g_rot
        assign rotated[gi] = t_q[(gi + NUM_T - 1) % NUM_T];
    end

    always_comb begin
        t_d = t_q;
        if (advance_i && !hold_i) begin
            t_d = restart_i ? NUM_T'(1) : rotated;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q <= NUM_T'(1);
        end else begin
            t_q <= t_d;
        end
    end

    assign t_state_o = t_q;

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 controller: T-state ring plus opcode decoder driving every datapath
// control line, with free-run/single-step advance and a sticky HALT.
module control_sequencer
    import sap1_pkg::*;
#(
    parameter int NUM_T        = SAP1_NUM_T,
    parameter bit EARLY_RETIRE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [3:0]       opcode,
    output logic [NUM_T-1:0] t_state,
    output logic             halted,
    output logic             pc_out,
    output logic             pc_inc,
    output logic             mar_load,
    output logic             ram_out,
    output logic             instr_load,
    output logic             instr_send,
    output logic             a_load,
    output logic             a_out,
    output logic             b_load,
    output logic             alu_sub,
    output logic             alu_out,
    output logic             out_load
);

    logic             halted_q;
    logic             halted_d;
    logic             advance;
    logic             restart;
    logic             hold;
    logic [NUM_T-1:0] t_q;
    ctrl_word_t       cw;

    // Reset also blanks the control word so nothing fires while rst is high.
    assign advance = ~rst & ~halted_q & (run | step);

    always_comb begin
        restart = 1'b0;
        if (EARLY_RETIRE) begin
            if (t_q[T5] && (opcode == OP_LDA)) begin
                restart = 1'b1;
            end
            if (t_q[T4] && !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_HLT})) begin
                restart = 1'b1;
            end
        end
    end

    assign hold     = t_q[T4] & (opcode == OP_HLT);
    assign halted_d = halted_q | (advance & hold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    t_ring_counter #(
        .NUM_T(NUM_T)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .advance_i (advance),
        .restart_i (restart),
        .hold_i    (hold),
        .t_state_o (t_q)
    );

    assign cw = advance ? decode(t_q, opcode) : '0;

    assign t_state    = t_q;
    assign halted     = halted_q;
    assign pc_out     = cw[CW_PC_OUT];
    assign pc_inc     = cw[CW_PC_INC];
    assign mar_load   = cw[CW_MAR_LOAD];
    assign ram_out    = cw[CW_RAM_OUT];
    assign instr_load = cw[CW_INSTR_LOAD];
    assign instr_send = cw[CW_INSTR_SEND];
    assign a_load     = cw[CW_A_LOAD];
    assign a_out      = cw[CW_A_OUT];
    assign b_load     = cw[CW_B_LOAD];
    assign alu_sub    = cw[CW_ALU_SUB];
    assign alu_out    = cw[CW_ALU_OUT];
    assign out_load   = cw[CW_OUT_LOAD];

endmodule
